// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-controller bus bundle: EXU redirect, AXI4-Lite AR/R read channels and IDU handoff.
// "master" is the fetch controller side, "slave" the memory/EXU/IDU environment side.
interface ifu_fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] araddr;
    logic            arvalid;
    logic            arready;
    logic [XLEN-1:0] rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;

    modport master (
        input  redir_valid, redir_pc, arready, rdata, rresp, rvalid, inst_ready,
        output araddr, arvalid, rready, inst_valid, inst, inst_pc, inst_fault
    );

    modport slave (
        output redir_valid, redir_pc, arready, rdata, rresp, rvalid, inst_ready,
        input  araddr, arvalid, rready, inst_valid, inst, inst_pc, inst_fault
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle instruction fetch controller: owns the PC, issues one AXI4-Lite read per
// instruction and hands each word to decode over valid/ready, honouring EXU redirects.
module ifu_fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    ifu_fetch_ctrl_if.master    fetch_if
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_drop;
    logic            r_arvalid;
    logic            r_rready;
    logic            r_inst_valid;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_inst_fault;

    logic [XLEN-1:0] w_redir_pc;
    logic            w_fault;
    logic            w_unused;

    assign w_redir_pc = {fetch_if.redir_pc[XLEN-1:2], 2'b00};
    assign w_fault    = (fetch_if.rresp != 2'b00);
    assign w_unused   = &{1'b0, fetch_if.redir_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_drop       <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_if.redir_valid) r_pc <= w_redir_pc;
                    r_arvalid <= 1'b1;
                    r_state   <= S_REQ;
                end
                S_REQ: begin
                    // Redirect cannot cancel an offered address; remember it and drop the reply.
                    if (fetch_if.redir_valid) begin
                        r_drop    <= 1'b1;
                        r_pend_pc <= w_redir_pc;
                    end
                    if (fetch_if.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fetch_if.rvalid) begin
                        r_rready <= 1'b0;
                        if (r_drop || fetch_if.redir_valid) begin
                            r_pc      <= fetch_if.redir_valid ? w_redir_pc : r_pend_pc;
                            r_drop    <= 1'b0;
                            r_arvalid <= 1'b1;
                            r_state   <= S_REQ;
                        end else begin
                            r_inst       <= w_fault ? '0 : fetch_if.rdata;
                            r_inst_pc    <= r_pc;
                            r_inst_fault <= w_fault;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end else if (fetch_if.redir_valid) begin
                        r_drop    <= 1'b1;
                        r_pend_pc <= w_redir_pc;
                    end
                end
                S_HOLD: begin
                    // A redirect in the consume cycle still retires the word but wins the PC.
                    if (fetch_if.redir_valid || fetch_if.inst_ready) begin
                        r_pc         <= fetch_if.redir_valid ? w_redir_pc : r_pc + XLEN'(4);
                        r_inst_valid <= 1'b0;
                        r_arvalid    <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fetch_if.araddr     = r_pc;
    assign fetch_if.arvalid    = r_arvalid;
    assign fetch_if.rready     = r_rready;
    assign fetch_if.inst_valid = r_inst_valid;
    assign fetch_if.inst       = r_inst;
    assign fetch_if.inst_pc    = r_inst_pc;
    assign fetch_if.inst_fault = r_inst_fault;
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized bench for ifu_fetch_ctrl: a transaction-level fetch model predicts every
// address, handoff word and handshake level, with a latency-shaped memory responder.
module tb_ifu_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          NCYC   = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_fetch_ctrl_if #(.XLEN(32)) bus ();

    ifu_fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_if (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: where the fetch stream stands and what the IDU should currently see
    bit          m_idle, m_outst, m_hold, m_disc;
    logic [31:0] m_addr, m_pend, m_inst, m_ipc;
    logic        m_fault;

    // Memory responder and stimulus knobs
    int ar_wait, ar_dly, r_dly;
    int k_ar_min, k_ar_max, k_r_max, p_ready, p_redir, p_err, p_rst;
    int last_iv = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] msk(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_outst = 1'b0;
        m_hold  = 1'b0;
        m_disc  = 1'b0;
        m_addr  = RST_PC;
        m_pend  = '0;
        m_inst  = '0;
        m_ipc   = '0;
        m_fault = 1'b0;
        ar_wait = 0;
        ar_dly  = $urandom_range(k_ar_max, k_ar_min);
        r_dly   = 0;
    endtask

    task automatic drive(input int cyc);
        bit req;
        if (cyc == 40) begin
            k_ar_min = 4; k_ar_max = 4; k_r_max = 2; p_ready = 30;
        end
        if (cyc == 80) begin
            k_ar_min = 0; k_ar_max = 3; k_r_max = 3; p_ready = 60;
            p_redir = 12; p_err = 15; p_rst = 4;
        end
        rst = !(cyc < 2 || $urandom_range(0, 999) < p_rst);
        bus.redir_valid = ($urandom_range(0, 99) < p_redir);
        case ($urandom_range(0, 3))
            0:       bus.redir_pc = 32'h8000_0100;
            1:       bus.redir_pc = 32'h8000_0203;
            2:       bus.redir_pc = 32'hFFFF_FFFF;
            default: bus.redir_pc = $urandom;
        endcase
        req = !m_idle && !m_outst && !m_hold;
        bus.arready = req ? (ar_wait >= ar_dly) : 1'($urandom_range(0, 1));
        if (m_outst) begin
            bus.rvalid = (r_dly == 0);
            if (r_dly > 0) r_dly--;
        end else begin
            bus.rvalid = 1'b0;
        end
        if (cyc < 40)                       bus.rdata = 32'h0000_0013;
        else if ($urandom_range(0, 3) == 0) bus.rdata = 32'hDEAD_BEEF;
        else                                bus.rdata = $urandom;
        bus.rresp      = ($urandom_range(0, 99) < p_err) ? 2'($urandom_range(1, 3)) : 2'b00;
        bus.inst_ready = ($urandom_range(0, 99) < p_ready);
    endtask

    task automatic check_and_step(input int cyc);
        bit req;
        req = !m_idle && !m_outst && !m_hold;
        chk("arvalid", 32'(bus.arvalid), 32'(req));
        chk("rready", 32'(bus.rready), 32'(m_outst));
        chk("inst_valid", 32'(bus.inst_valid), 32'(m_hold));
        chk("ar_r_excl", 32'(bus.arvalid && bus.rready), 32'd0);
        chk("inst", bus.inst, m_inst);
        chk("inst_pc", bus.inst_pc, m_ipc);
        chk("inst_fault", 32'(bus.inst_fault), 32'(m_fault));
        if (req || m_idle) chk("araddr", bus.araddr, m_addr);
        if (cyc < 40 && bus.inst_valid) begin
            if (last_iv >= 0) chk("iv_period", 32'(cyc - last_iv), 32'd3);
            last_iv = cyc;
        end

        if (!rst) begin
            model_reset();
        end else if (m_idle) begin
            if (bus.redir_valid) m_addr = msk(bus.redir_pc);
            m_idle = 1'b0;
        end else if (m_hold) begin
            if (bus.redir_valid) begin
                m_addr = msk(bus.redir_pc);
                m_hold = 1'b0;
            end else if (bus.inst_ready) begin
                m_addr = m_ipc + 32'd4;
                m_hold = 1'b0;
            end
        end else if (!m_outst) begin
            if (bus.redir_valid) begin
                m_disc = 1'b1;
                m_pend = msk(bus.redir_pc);
            end
            if (bus.arready) begin
                m_outst = 1'b1;
                r_dly   = $urandom_range(0, k_r_max);
                ar_wait = 0;
                ar_dly  = $urandom_range(k_ar_max, k_ar_min);
            end else begin
                ar_wait++;
            end
        end else if (bus.rvalid) begin
            m_outst = 1'b0;
            if (m_disc || bus.redir_valid) begin
                m_addr = bus.redir_valid ? msk(bus.redir_pc) : m_pend;
                m_disc = 1'b0;
            end else begin
                m_fault = (bus.rresp != 2'b00);
                m_inst  = m_fault ? 32'd0 : bus.rdata;
                m_ipc   = m_addr;
                m_hold  = 1'b1;
            end
        end else if (bus.redir_valid) begin
            m_disc = 1'b1;
            m_pend = msk(bus.redir_pc);
        end
    endtask

    initial begin
        k_ar_min = 0; k_ar_max = 0; k_r_max = 0;
        p_ready = 100; p_redir = 0; p_err = 0; p_rst = 0;
        rst = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        bus.arready     = 1'b0;
        bus.rdata       = '0;
        bus.rresp       = 2'b00;
        bus.rvalid      = 1'b0;
        bus.inst_ready  = 1'b0;
        model_reset();
        @(posedge clk);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            #1;
            drive(cyc);
            @(negedge clk);
            check_and_step(cyc);
            @(posedge clk);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
